// File: rtl/lenet_sched_if.sv
//------------------------------------------------------------------------------
// Module : lenet_sched_if
// Brief  : Control/status bundle between the LeNet sequencer and its neighbours.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lenet_sched_if;
  logic       btn;
  logic       vga_vsync;
  logic       lenet_done;
  logic       bound_doing;
  logic       lenet_doing;
  logic       frame_freeze;
  logic       lenet_start;
  logic       timeout_err;
  logic [2:0] state_o;

  modport master (
    output btn, vga_vsync, lenet_done,
    input  bound_doing, lenet_doing, frame_freeze, lenet_start, timeout_err, state_o
  );

  modport slave (
    input  btn, vga_vsync, lenet_done,
    output bound_doing, lenet_doing, frame_freeze, lenet_start, timeout_err, state_o
  );
endinterface

`default_nettype wire

// File: rtl/lenet_sched.sv
//------------------------------------------------------------------------------
// Module : lenet_sched
// Brief  : Capture -> LeNet -> display sequencer with classifier watchdog.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lenet_sched #(
  parameter logic VSYNC_ACTIVE   = 1'b0,
  parameter int   SHOW_FRAMES    = 120,
  parameter int   TIMEOUT_CYCLES = 24_000_000
) (
  input  wire logic     clk24,
  input  wire logic     rst,
  lenet_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOUND  = 3'd1,
    S_WAIT_F = 3'd2,
    S_SETTLE = 3'd3,
    S_START  = 3'd4,
    S_RUN    = 3'd5,
    S_SHOW   = 3'd6
  } state_t;

  localparam int              c_TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      c_FLAST = 8'(SHOW_FRAMES - 1);

  state_t          r_state;
  state_t          w_nxt;
  logic            w_tmo;
  logic            r_btn_s1, r_btn_s2, r_btn_s3;
  logic            r_vs, r_vs_d;
  logic [c_TW-1:0] r_tcnt;
  logic [7:0]      r_fcnt;
  logic            r_bound, r_doing, r_freeze, r_start, r_terr;

  wire logic w_btn_pe   = r_btn_s2 & ~r_btn_s3;
  wire logic w_frame_pe = (r_vs == VSYNC_ACTIVE) && (r_vs_d != VSYNC_ACTIVE);

  always_comb begin
    w_nxt = r_state;
    w_tmo = 1'b0;
    case (r_state)
      S_IDLE:   if (w_btn_pe)   w_nxt = S_BOUND;
      S_BOUND:  if (w_btn_pe)   w_nxt = S_WAIT_F;
      S_WAIT_F: if (w_frame_pe) w_nxt = S_SETTLE;
      S_SETTLE: if (w_frame_pe) w_nxt = S_START;
      S_START:                  w_nxt = S_RUN;
      S_RUN: begin
        // a result arriving on the last allowed cycle still counts
        if (bus.lenet_done) begin
          w_nxt = S_SHOW;
        end else if (r_tcnt == c_TLAST) begin
          w_nxt = S_IDLE;
          w_tmo = 1'b1;
        end
      end
      S_SHOW: begin
        if (w_btn_pe)
          w_nxt = S_BOUND;
        else if (w_frame_pe && (r_fcnt == c_FLAST))
          w_nxt = S_IDLE;
      end
      default:                  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_s3 <= 1'b0;
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
      r_tcnt   <= '0;
      r_fcnt   <= '0;
      r_bound  <= 1'b0;
      r_doing  <= 1'b0;
      r_freeze <= 1'b0;
      r_start  <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_btn_s1 <= bus.btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      r_vs     <= bus.vga_vsync;
      r_vs_d   <= r_vs;
      r_state  <= w_nxt;

      if (w_nxt == S_RUN && r_state != S_RUN)
        r_tcnt <= '0;
      else if (r_state == S_RUN)
        r_tcnt <= r_tcnt + 1'b1;

      if (w_nxt == S_SHOW && r_state != S_SHOW)
        r_fcnt <= '0;
      else if (r_state == S_SHOW && w_frame_pe)
        r_fcnt <= r_fcnt + 1'b1;

      if (w_tmo)
        r_terr <= 1'b1;
      else if (r_state == S_IDLE && w_btn_pe)
        r_terr <= 1'b0;

      // outputs follow the next state so they switch on the same edge
      r_bound  <= (w_nxt == S_BOUND)  || (w_nxt == S_WAIT_F) || (w_nxt == S_SETTLE) ||
                  (w_nxt == S_START)  || (w_nxt == S_RUN);
      r_freeze <= (w_nxt == S_SETTLE) || (w_nxt == S_START)  || (w_nxt == S_RUN);
      r_start  <= (w_nxt == S_START);
      r_doing  <= (w_nxt == S_SHOW);
    end
  end

  assign bus.bound_doing  = r_bound;
  assign bus.lenet_doing  = r_doing;
  assign bus.frame_freeze = r_freeze;
  assign bus.lenet_start  = r_start;
  assign bus.timeout_err  = r_terr;
  assign bus.state_o      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_lenet_sched.sv
//------------------------------------------------------------------------------
// Module : tb_lenet_sched
// Brief  : Directed self-checking bench for lenet_sched.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lenet_sched;

  logic clk24;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   vs_cnt;

  lenet_sched_if u_if ();

  lenet_sched #(
    .VSYNC_ACTIVE   (1'b0),
    .SHOW_FRAMES    (3),
    .TIMEOUT_CYCLES (100)
  ) u_dut (
    .clk24 (clk24),
    .rst   (rst),
    .bus   (u_if.slave)
  );

  // {bound_doing, lenet_doing, frame_freeze, lenet_start, timeout_err}
  logic [4:0] w_outs;
  assign w_outs = {u_if.bound_doing, u_if.lenet_doing, u_if.frame_freeze,
                   u_if.lenet_start, u_if.timeout_err};

  initial begin
    clk24 = 1'b0;
    forever #5 clk24 = ~clk24;
  end

  // vsync: period 1000 cycles, low (active) for the first 10 of each period
  initial begin
    vs_cnt         = 0;
    u_if.vga_vsync = 1'b1;
    forever begin
      @(posedge clk24);
      #2;
      vs_cnt++;
      u_if.vga_vsync = ((vs_cnt % 1000) < 10) ? 1'b0 : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [4:0] outs);
    chk({tag, "_state"}, 32'(u_if.state_o), 32'(st));
    chk({tag, "_outs"},  32'(w_outs),       32'(outs));
  endtask

  // returns at the negedge following the vsync tick whose phase equals ph
  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk24);
      n++;
    end while (((vs_cnt % 1000) != ph) && (n < 1100));
    if (n >= 1100) chk("wait_phase_timeout", 32'd1, 32'd0);
  endtask

  // btn_pe lands in the third cycle; returns just after the resulting state edge
  task automatic press();
    @(posedge clk24);
    #2;
    u_if.btn = 1'b1;
    repeat (3) @(posedge clk24);
    @(negedge clk24);
    u_if.btn = 1'b0;
  endtask

  // from BOUND: second press, two frame edges, START pulse, RUN entry
  task automatic bound_to_run(input bit poke);
    wait_phase(100);
    press();
    chk_st("wait_f", 3'd2, 5'b10000);
    wait_phase(0);
    @(negedge clk24);
    chk_st("settle_pre", 3'd2, 5'b10000);
    @(negedge clk24);
    chk_st("settle", 3'd3, 5'b10100);
    if (poke) begin
      repeat (100) @(negedge clk24);
      press();
      chk_st("settle_btn_ign", 3'd3, 5'b10100);
    end
    wait_phase(0);
    @(negedge clk24);
    chk_st("start_pre", 3'd3, 5'b10100);
    @(negedge clk24);
    chk_st("start", 3'd4, 5'b10110);
    @(negedge clk24);
    chk_st("run", 3'd5, 5'b10100);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b0;
    u_if.btn        = 1'b0;
    u_if.lenet_done = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk24);
    chk_st("reset", 3'd0, 5'b00000);
    rst = 1'b0;

    // sub-cycle glitch never reaches a clock edge
    @(negedge clk24);
    u_if.btn = 1'b1;
    #2 u_if.btn = 1'b0;
    repeat (5) @(negedge clk24);
    chk_st("glitch", 3'd0, 5'b00000);

    // normal flow with ignored presses in SETTLE and RUN
    wait_phase(100);
    press();
    chk_st("bound", 3'd1, 5'b10000);
    bound_to_run(1'b1);
    press();
    chk_st("run_btn_ign", 3'd5, 5'b10100);
    repeat (45) @(negedge clk24);
    u_if.lenet_done = 1'b1;
    @(negedge clk24);
    u_if.lenet_done = 1'b0;
    chk_st("show", 3'd6, 5'b01000);
    for (int f = 1; f <= 3; f++) begin
      wait_phase(0);
      @(negedge clk24);
      chk_st("show_hold", 3'd6, 5'b01000);
      @(negedge clk24);
      if (f < 3) chk_st("show_frame", 3'd6, 5'b01000);
      else       chk_st("show_exit", 3'd0, 5'b00000);
    end

    // timeout with no lenet_done
    wait_phase(100);
    press();
    chk_st("bound2", 3'd1, 5'b10000);
    bound_to_run(1'b0);
    repeat (99) @(negedge clk24);
    chk_st("run_pre_tmo", 3'd5, 5'b10100);
    @(negedge clk24);
    chk_st("tmo_idle", 3'd0, 5'b00001);
    press();
    chk_st("terr_clear", 3'd1, 5'b10000);

    // lenet_done on the exact timeout cycle
    bound_to_run(1'b0);
    repeat (99) @(negedge clk24);
    u_if.lenet_done = 1'b1;
    @(negedge clk24);
    u_if.lenet_done = 1'b0;
    chk_st("done_at_tmo", 3'd6, 5'b01000);

    // press coinciding with the terminal frame edge of SHOW
    for (int f = 1; f <= 2; f++) begin
      wait_phase(0);
      @(negedge clk24);
      @(negedge clk24);
      chk_st("show2_frame", 3'd6, 5'b01000);
    end
    wait_phase(998);
    @(posedge clk24);
    #2;
    u_if.btn = 1'b1;
    repeat (3) @(posedge clk24);
    @(negedge clk24);
    u_if.btn = 1'b0;
    chk_st("show_btn_term", 3'd1, 5'b10000);

    // asynchronous reset while running
    bound_to_run(1'b0);
    repeat (10) @(negedge clk24);
    #1 rst = 1'b1;
    #1 chk_st("rst_async", 3'd0, 5'b00000);
    @(negedge clk24);
    rst = 1'b0;
    repeat (3) @(negedge clk24);
    chk_st("rst_idle", 3'd0, 5'b00000);

    // short pulse spanning a single edge yields one step only
    @(negedge clk24);
    u_if.btn = 1'b1;
    @(posedge clk24);
    #1 u_if.btn = 1'b0;
    repeat (6) @(negedge clk24);
    chk_st("short_btn", 3'd1, 5'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
